// File: rtl/fee_config_axil_slave.sv
// AXI4-Lite slave holding the four-register FEE configuration map.
// Threshold, acquisition and baseline registers accept writes only while SET_CONFIG is set.
module fee_config_axil_slave #(
  parameter int unsigned ADDR_WIDTH       = 6,
  parameter logic [15:0] RST_MAX_TRIG_LEN = 16'd32,
  parameter logic [15:0] RST_RISING_THR   = 16'd1024,
  parameter logic [15:0] RST_FALLING_THR  = 16'd512,
  parameter logic [1:0]  RST_PRE_ACQ      = 2'd1,
  parameter logic [1:0]  RST_POST_ACQ     = 2'd1,
  parameter logic [12:0] RST_H_BASELINE   = 13'd1024,
  parameter logic [15:0] RST_L_BASELINE   = 16'd128
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic                  SET_CONFIG,
  output logic                  STOP,
  output logic                  ACQUIRE_MODE,
  output logic [15:0]           MAX_TRIGGER_LENGTH,
  output logic [15:0]           RISING_EDGE_THRESHOLD,
  output logic [15:0]           FALLING_EDGE_THRESHOLD,
  output logic [1:0]            PRE_ACQUISITION_LENGTH,
  output logic [1:0]            POST_ACQUISITION_LENGTH,
  output logic [12:0]           H_GAIN_BASELINE,
  output logic [15:0]           L_GAIN_BASELINE
);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] data,
                                              input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : cur[b*8 +: 8];
    return res;
  endfunction

  logic [2:0]  mode;
  logic [15:0] max_trig;
  logic [15:0] rising_thr;
  logic [15:0] falling_thr;
  logic [1:0]  pre_acq;
  logic [1:0]  post_acq;
  logic [12:0] h_base;
  logic [15:0] l_base;
  logic [31:0] reg_view [4];

  always_comb begin
    reg_view[0] = {13'b0, mode, max_trig};
    reg_view[1] = {rising_thr, falling_thr};
    reg_view[2] = {28'b0, pre_acq, post_acq};
    reg_view[3] = {3'b0, h_base, l_base};
  end

  // Handshake readiness is held off until the first clock after reset release.
  logic                  ready_en;
  logic [0:0]            w_state;
  logic [0:0]            r_state;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;
  logic [1:0]            bresp_q;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [1:0]            wr_idx;
  logic                  wr_mapped;
  logic [1:0]            wr_resp;
  logic [31:0]           wr_word;
  logic [1:0]            rd_idx;
  logic                  rd_mapped;
  logic                  unused_bits;

  assign S_AXI_AWREADY = ready_en && (w_state == W_IDLE) && !aw_held;
  assign S_AXI_WREADY  = ready_en && (w_state == W_IDLE) && !w_held;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ready_en && (r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit  = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  // A beat arriving this cycle bypasses its holding register so commit needs no extra cycle.
  assign wr_addr   = aw_held ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data   = w_held ? w_data_q : S_AXI_WDATA;
  assign wr_strb   = w_held ? w_strb_q : S_AXI_WSTRB;
  assign wr_idx    = wr_addr[3:2];
  assign wr_mapped = (wr_addr[ADDR_WIDTH-1:4] == '0);
  assign wr_word   = merge_bytes(reg_view[wr_idx], wr_data, wr_strb);

  always_comb begin
    wr_resp = RESP_OKAY;
    if (!wr_mapped)
      wr_resp = RESP_DECERR;
    else if ((wr_idx != 2'd0) && !mode[2])
      wr_resp = RESP_SLVERR;
  end

  assign wr_en     = commit && (wr_resp == RESP_OKAY);
  assign rd_idx    = S_AXI_ARADDR[3:2];
  assign rd_mapped = (S_AXI_ARADDR[ADDR_WIDTH-1:4] == '0);

  assign unused_bits = ^{wr_addr[1:0], S_AXI_ARADDR[1:0], wr_word};

  always_ff @(posedge CLK) begin
    if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
    if (w_hs) begin
      w_data_q <= S_AXI_WDATA;
      w_strb_q <= S_AXI_WSTRB;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ready_en <= 1'b0;
      w_state  <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      case (w_state)
        W_IDLE: begin
          if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= wr_resp;
            w_state <= W_RESP;
          end else begin
            if (aw_hs) aw_held <= 1'b1;
            if (w_hs)  w_held  <= 1'b1;
          end
        end
        default: if (S_AXI_BREADY) w_state <= W_IDLE;
      endcase
    end
  end

  // Reads sample the registers on the same edge a write commits, so they see the pre-write value.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q <= rd_mapped ? reg_view[rd_idx] : 32'h0;
            rresp_q <= rd_mapped ? RESP_OKAY : RESP_DECERR;
            r_state <= R_DATA;
          end
        end
        default: if (S_AXI_RREADY) r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      mode        <= 3'b010;
      max_trig    <= RST_MAX_TRIG_LEN;
      rising_thr  <= RST_RISING_THR;
      falling_thr <= RST_FALLING_THR;
      pre_acq     <= RST_PRE_ACQ;
      post_acq    <= RST_POST_ACQ;
      h_base      <= RST_H_BASELINE;
      l_base      <= RST_L_BASELINE;
    end else if (wr_en) begin
      case (wr_idx)
        2'd0: begin
          mode     <= wr_word[18:16];
          max_trig <= wr_word[15:0];
        end
        2'd1: begin
          rising_thr  <= wr_word[31:16];
          falling_thr <= wr_word[15:0];
        end
        2'd2: begin
          pre_acq  <= wr_word[3:2];
          post_acq <= wr_word[1:0];
        end
        default: begin
          h_base <= wr_word[28:16];
          l_base <= wr_word[15:0];
        end
      endcase
    end
  end

  assign SET_CONFIG              = mode[2];
  assign STOP                    = mode[1];
  assign ACQUIRE_MODE            = mode[0];
  assign MAX_TRIGGER_LENGTH      = max_trig;
  assign RISING_EDGE_THRESHOLD   = rising_thr;
  assign FALLING_EDGE_THRESHOLD  = falling_thr;
  assign PRE_ACQUISITION_LENGTH  = pre_acq;
  assign POST_ACQUISITION_LENGTH = post_acq;
  assign H_GAIN_BASELINE         = h_base;
  assign L_GAIN_BASELINE         = l_base;

endmodule

// File: tb/tb_fee_config_axil_slave.sv
// Directed bench for fee_config_axil_slave: register map, config-mode gating, channel ordering,
// decode errors, byte strobes, read/write collision and mid-transaction reset.
module tb_fee_config_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [5:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        set_config, stop, acquire_mode;
  logic [15:0] max_trig, rising, falling, l_base;
  logic [1:0]  pre_acq, post_acq;
  logic [12:0] h_base;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fee_config_axil_slave dut (
    .CLK(clk), .RESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .SET_CONFIG(set_config), .STOP(stop), .ACQUIRE_MODE(acquire_mode),
    .MAX_TRIGGER_LENGTH(max_trig), .RISING_EDGE_THRESHOLD(rising),
    .FALLING_EDGE_THRESHOLD(falling), .PRE_ACQUISITION_LENGTH(pre_acq),
    .POST_ACQUISITION_LENGTH(post_acq), .H_GAIN_BASELINE(h_base), .L_GAIN_BASELINE(l_base)
  );

  // Full write transaction with BREADY high; lat counts cycles between AW/W completion and BVALID.
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    int  n = 0;
    logic aw_f, w_f;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    while ((awvalid || wvalid) && n < 50) begin
      aw_f = awready; w_f = wready;
      @(negedge clk); n++;
      if (aw_f) awvalid = 1'b0;
      if (w_f)  wvalid  = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 50) begin @(negedge clk); lat++; end
    n_checks++;
    if (!bvalid) begin n_fail++; $display("FAIL write_timeout addr %h: bvalid never rose", a); end
    resp = bresp;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); arvalid = 1'b0;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (!rvalid) begin n_fail++; $display("FAIL read_timeout addr %h: rvalid never rose", a); end
    d = rdata; resp = rresp;
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({set_config, stop, acquire_mode} !== 3'b010) begin n_fail++; $display("FAIL rst_mode: got %b expected 010", {set_config, stop, acquire_mode}); end
    n_checks++; if (max_trig !== 16'd32) begin n_fail++; $display("FAIL rst_max_trig: got %0d expected 32", max_trig); end
    n_checks++; if ({rising, falling} !== {16'd1024, 16'd512}) begin n_fail++; $display("FAIL rst_thr: got %h expected %h", {rising, falling}, {16'd1024, 16'd512}); end
    n_checks++; if ({pre_acq, post_acq} !== 4'b0101) begin n_fail++; $display("FAIL rst_acq: got %b expected 0101", {pre_acq, post_acq}); end
    n_checks++; if ({h_base, l_base} !== {13'd1024, 16'd128}) begin n_fail++; $display("FAIL rst_base: got %h expected %h", {h_base, l_base}, {13'd1024, 16'd128}); end
    n_checks++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin n_fail++; $display("FAIL rst_handshake: got %b expected 00000", {awready, wready, arready, bvalid, rvalid}); end
    n_checks++; if ({bresp, rresp, rdata} !== 36'h0) begin n_fail++; $display("FAIL rst_resp_data: got %h expected 0", {bresp, rresp, rdata}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({awready, wready, arready} !== 3'b111) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 111", {awready, wready, arready}); end
  endtask

  task automatic test_config_writes();
    logic [1:0] r; int lat; logic [31:0] d;
    axi_write(6'h00, 32'h0006_0020, 4'hF, r, lat);
    n_checks++; if (r !== 2'b00) begin n_fail++; $display("FAIL cfg_w0_resp: got %b expected 00", r); end
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL cfg_w0_latency: got %0d expected 0", lat); end
    n_checks++; if ({set_config, stop, acquire_mode, max_trig} !== {3'b110, 16'h0020}) begin n_fail++; $display("FAIL cfg_reg0: got %h expected %h", {set_config, stop, acquire_mode, max_trig}, {3'b110, 16'h0020}); end
    axi_write(6'h04, 32'h1234_0567, 4'hF, r, lat);
    n_checks++; if ({r, rising, falling} !== {2'b00, 32'h1234_0567}) begin n_fail++; $display("FAIL cfg_thr_a: got %h expected %h", {r, rising, falling}, {2'b00, 32'h1234_0567}); end
    axi_write(6'h04, 32'h0400_0200, 4'hF, r, lat);
    n_checks++; if ({r, rising, falling} !== {2'b00, 32'h0400_0200}) begin n_fail++; $display("FAIL cfg_thr_b: got %h expected %h", {r, rising, falling}, {2'b00, 32'h0400_0200}); end
    axi_write(6'h08, 32'h0000_000E, 4'hF, r, lat);
    n_checks++; if ({r, pre_acq, post_acq} !== {2'b00, 2'd3, 2'd2}) begin n_fail++; $display("FAIL cfg_acq_e: got %b expected 001110", {r, pre_acq, post_acq}); end
    axi_read(6'h08, d, r);
    n_checks++; if ({r, d} !== {2'b00, 32'h0000_000E}) begin n_fail++; $display("FAIL cfg_rd_acq: got %h expected %h", {r, d}, {2'b00, 32'h0000_000E}); end
    axi_write(6'h08, 32'h0000_0005, 4'hF, r, lat);
    n_checks++; if ({r, pre_acq, post_acq} !== {2'b00, 2'd1, 2'd1}) begin n_fail++; $display("FAIL cfg_acq_5: got %b expected 000101", {r, pre_acq, post_acq}); end
    axi_write(6'h0C, 32'hFFFF_FFFF, 4'hF, r, lat);
    n_checks++; if ({h_base, l_base} !== {13'h1FFF, 16'hFFFF}) begin n_fail++; $display("FAIL cfg_base_ones: got %h expected %h", {h_base, l_base}, {13'h1FFF, 16'hFFFF}); end
    axi_read(6'h0C, d, r);
    n_checks++; if (d !== 32'h1FFF_FFFF) begin n_fail++; $display("FAIL cfg_rd_base: got %h expected 1fffffff", d); end
    axi_write(6'h0C, 32'h0400_0080, 4'hF, r, lat);
    n_checks++; if ({r, h_base, l_base} !== {2'b00, 13'd1024, 16'd128}) begin n_fail++; $display("FAIL cfg_base: got %h expected %h", {r, h_base, l_base}, {2'b00, 13'd1024, 16'd128}); end
  endtask

  task automatic test_config_gate();
    logic [1:0] r; int lat; logic [31:0] d;
    axi_write(6'h00, 32'h0000_0020, 4'hF, r, lat);
    n_checks++; if ({r, set_config, stop, acquire_mode} !== 5'b00000) begin n_fail++; $display("FAIL gate_mode_run: got %b expected 00000", {r, set_config, stop, acquire_mode}); end
    axi_write(6'h04, 32'hFFFF_FFFF, 4'hF, r, lat);
    n_checks++; if (r !== 2'b10) begin n_fail++; $display("FAIL gate_slverr: got %b expected 10", r); end
    n_checks++; if ({rising, falling} !== 32'h0400_0200) begin n_fail++; $display("FAIL gate_thr_kept: got %h expected 04000200", {rising, falling}); end
    axi_read(6'h04, d, r);
    n_checks++; if ({r, d} !== {2'b00, 32'h0400_0200}) begin n_fail++; $display("FAIL gate_rd_thr: got %h expected %h", {r, d}, {2'b00, 32'h0400_0200}); end
    axi_write(6'h0C, 32'h0000_0000, 4'hF, r, lat);
    n_checks++; if ({r, l_base} !== {2'b10, 16'd128}) begin n_fail++; $display("FAIL gate_base: got %h expected %h", {r, l_base}, {2'b10, 16'd128}); end
    axi_write(6'h00, 32'h0001_0020, 4'hF, r, lat);
    axi_read(6'h00, d, r);
    n_checks++; if ({acquire_mode, d} !== {1'b1, 32'h0001_0020}) begin n_fail++; $display("FAIL gate_combined: got %h expected %h", {acquire_mode, d}, {1'b1, 32'h0001_0020}); end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r; int lat; logic [31:0] d;
    axi_write(6'h00, 32'h0006_0020, 4'hF, r, lat);
    @(negedge clk);
    wdata = 32'h0000_000E; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    n_checks++; if (wready !== 1'b1) begin n_fail++; $display("FAIL order_wready: got %b expected 1", wready); end
    @(negedge clk); wvalid = 1'b0;
    repeat (3) begin
      n_checks++; if ({bvalid, wready, awready} !== 3'b001) begin n_fail++; $display("FAIL order_w_held: got %b expected 001", {bvalid, wready, awready}); end
      @(negedge clk);
    end
    awaddr = 6'h08; awvalid = 1'b1;
    n_checks++; if (awready !== 1'b1) begin n_fail++; $display("FAIL order_awready: got %b expected 1", awready); end
    @(negedge clk); awvalid = 1'b0;
    repeat (5) begin
      n_checks++; if ({bvalid, bresp, awready, wready, pre_acq, post_acq} !== {1'b1, 2'b00, 2'b00, 2'd3, 2'd2}) begin n_fail++; $display("FAIL order_bhold: got %b expected 100001110", {bvalid, bresp, awready, wready, pre_acq, post_acq}); end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    n_checks++; if ({bvalid, awready, wready} !== 3'b011) begin n_fail++; $display("FAIL order_bdone: got %b expected 011", {bvalid, awready, wready}); end
    axi_read(6'h08, d, r);
    n_checks++; if (d !== 32'h0000_000E) begin n_fail++; $display("FAIL order_rd_acq: got %h expected 0000000e", d); end
  endtask

  task automatic test_decode_strobe();
    logic [1:0] r; int lat; logic [31:0] d;
    axi_write(6'h10, 32'h0000_1234, 4'hF, r, lat);
    n_checks++; if ({r, max_trig} !== {2'b11, 16'h0020}) begin n_fail++; $display("FAIL dec_wr: got %h expected %h", {r, max_trig}, {2'b11, 16'h0020}); end
    axi_read(6'h3C, d, r);
    n_checks++; if ({r, d} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL dec_rd: got %h expected %h", {r, d}, {2'b11, 32'h0}); end
    axi_read(6'h0D, d, r);
    n_checks++; if ({r, d} !== {2'b00, 32'h0400_0080}) begin n_fail++; $display("FAIL dec_lowbits: got %h expected %h", {r, d}, {2'b00, 32'h0400_0080}); end
    axi_write(6'h00, 32'h0000_00FF, 4'b0001, r, lat);
    n_checks++; if ({r, set_config, stop, acquire_mode, max_trig} !== {2'b00, 3'b110, 16'h00FF}) begin n_fail++; $display("FAIL strb_byte0: got %h expected %h", {r, set_config, stop, acquire_mode, max_trig}, {2'b00, 3'b110, 16'h00FF}); end
    axi_write(6'h00, 32'h0000_0000, 4'b0000, r, lat);
    n_checks++; if ({r, set_config, max_trig} !== {2'b00, 1'b1, 16'h00FF}) begin n_fail++; $display("FAIL strb_none: got %h expected %h", {r, set_config, max_trig}, {2'b00, 1'b1, 16'h00FF}); end
  endtask

  task automatic test_rw_collision();
    @(negedge clk);
    awaddr = 6'h04; awvalid = 1'b1; wdata = 32'hAAAA_5555; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 6'h04; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    n_checks++; if ({awready, wready, arready} !== 3'b111) begin n_fail++; $display("FAIL coll_ready: got %b expected 111", {awready, wready, arready}); end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n_checks++; if ({bvalid, rvalid, rdata} !== {2'b11, 32'h0400_0200}) begin n_fail++; $display("FAIL coll_rd_old: got %h expected %h", {bvalid, rvalid, rdata}, {2'b11, 32'h0400_0200}); end
    n_checks++; if ({rising, falling} !== 32'hAAAA_5555) begin n_fail++; $display("FAIL coll_wr_new: got %h expected aaaa5555", {rising, falling}); end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk); bready = 1'b0; rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    awaddr = 6'h00; awvalid = 1'b1; wdata = 32'h0006_1234; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 6'h08; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    n_checks++; if ({bvalid, rvalid, max_trig} !== {2'b11, 16'h1234}) begin n_fail++; $display("FAIL mid_setup: got %h expected %h", {bvalid, rvalid, max_trig}, {2'b11, 16'h1234}); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b0) begin n_fail++; $display("FAIL mid_channels: got %b expected 00000", {bvalid, rvalid, awready, wready, arready}); end
    n_checks++; if ({set_config, stop, acquire_mode, max_trig, rising, falling} !== {3'b010, 16'd32, 16'd1024, 16'd512}) begin n_fail++; $display("FAIL mid_regs: got %h expected %h", {set_config, stop, acquire_mode, max_trig, rising, falling}, {3'b010, 16'd32, 16'd1024, 16'd512}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({bvalid, rvalid, awready} !== 3'b001) begin n_fail++; $display("FAIL mid_recover: got %b expected 001", {bvalid, rvalid, awready}); end
  endtask

  initial begin
    test_reset();
    test_config_writes();
    test_config_gate();
    test_w_before_aw();
    test_decode_strobe();
    test_rw_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
